hd44780_rx: RTL and testbench

Receive-side model of the HD44780 4-bit parallel bus: samples `e`/`rs`/`db` as driven by the `hd44780` driver, reassembles command and data bytes, and tracks interface mode and busy time the way the LCD controller does. Used as the on-chip loopback checker and bench responder for the display path. It sits beside the driver on the same `e`/`rs`/`db` wires and runs on the system clock.

---
 rtl/hd44780_pkg.sv | 37 +++
 rtl/hd44780_rx_if.sv | 32 +++
 rtl/hd44780_strobe_sync.sv | 41 ++++
 rtl/hd44780_rx.sv | 164 ++++++++++++++++
 tb/tb_hd44780_rx.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hd44780_pkg.sv
// Shared HD44780 definitions: command opcodes, DDRAM line bounds and receiver states.
// Used by both the hd44780 driver and the hd44780_rx bus receiver.
package hd44780_pkg;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_ENTRY    = 8'h04;
    localparam logic [7:0] CMD_SHIFT    = 8'h10;
    localparam logic [7:0] CMD_FUNC     = 8'h20;
    localparam logic [7:0] CMD_SETDDRAM = 8'h80;

    localparam logic [6:0] LINE0_END   = 7'h27;
    localparam logic [6:0] LINE1_START = 7'h40;
    localparam logic [6:0] LINE1_END   = 7'h67;

    typedef enum logic [1:0] {
        ST_BYTE8 = 2'd0,
        ST_HI4   = 2'd1,
        ST_LO4   = 2'd2
    } rx_state_t;

    // Two-line DDRAM address step; the gap 0x28..0x3F is skipped in both directions.
    function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == LINE0_END)      n = LINE1_START;
            else if (a == LINE1_END) n = 7'h00;
            else                     n = a + 7'd1;
        end else begin
            if (a == 7'h00)            n = LINE1_END;
            else if (a == LINE1_START) n = LINE0_END;
            else                       n = a - 7'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/hd44780_rx_if.sv
// HD44780 bus pins plus the receiver's decoded outputs.
// The char/ddram members exist only when HD44780_RX_DDRAM_EN is defined.
interface hd44780_rx_if;
    logic       e;
    logic       rs;
    logic [3:0] db;
    logic       rx_valid;
    logic       rx_rs;
    logic [7:0] rx_data;
    logic       mode4;
    logic       busy;
    logic       overrun;
    logic       rs_err;
`ifdef HD44780_RX_DDRAM_EN
    logic       char_we;
    logic [6:0] char_addr;
    logic [7:0] char_data;
    logic [6:0] ddram_addr;

    modport master (output e, rs, db,
                    input  rx_valid, rx_rs, rx_data, mode4, busy, overrun, rs_err,
                           char_we, char_addr, char_data, ddram_addr);
    modport slave  (input  e, rs, db,
                    output rx_valid, rx_rs, rx_data, mode4, busy, overrun, rs_err,
                           char_we, char_addr, char_data, ddram_addr);
`else
    modport master (output e, rs, db,
                    input  rx_valid, rx_rs, rx_data, mode4, busy, overrun, rs_err);
    modport slave  (input  e, rs, db,
                    output rx_valid, rx_rs, rx_data, mode4, busy, overrun, rs_err);
`endif
endinterface

// File: rtl/hd44780_strobe_sync.sv
// Synchronizes e/rs/db, captures rs/db while e is high and emits a one-cycle
// strobe on the synced falling edge of e.
module hd44780_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic [3:0] db,
    output logic       strobe,
    output logic       cap_rs,
    output logic [3:0] cap_db
);

    logic [5:0] sync_q [SYNC_STAGES];
    logic       e_s;
    logic       e_d;

    assign e_s    = sync_q[SYNC_STAGES-1][5];
    assign strobe = e_d & ~e_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_d    <= 1'b0;
            cap_rs <= 1'b0;
            cap_db <= '0;
        end else begin
            sync_q[0] <= {e, rs, db};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            e_d <= e_s;
            // rs/db travel with e, so the captured value is the last one seen while e was high
            if (e_s) begin
                cap_rs <= sync_q[SYNC_STAGES-1][4];
                cap_db <= sync_q[SYNC_STAGES-1][3:0];
            end
        end
    end

endmodule

// File: rtl/hd44780_rx.sv
// HD44780 4-bit bus receiver: byte reassembly, interface mode and busy emulation.
// Optional DDRAM address tracker compiled in with HD44780_RX_DDRAM_EN.
//
// state    | meaning
// ST_BYTE8 | 8-bit mode, every strobe completes a byte {db, 4'h0}
// ST_HI4   | 4-bit mode, next strobe carries the high nibble
// ST_LO4   | 4-bit mode, next strobe carries the low nibble
module hd44780_rx
    import hd44780_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int BUSY_CYCLES      = 1000,
    parameter int LONG_BUSY_CYCLES = 44300
) (
    input logic           clk,
    input logic           rst,
    hd44780_rx_if.slave   bus
);

    localparam int CW = $clog2(LONG_BUSY_CYCLES + 1);

    rx_state_t   state, state_n;
    logic        strobe, cap_rs;
    logic [3:0]  cap_db;
    logic [3:0]  hi_nib;
    logic        hi_rs;
    logic        byte_done, byte_rs, hi_load, rs_mis;
    logic [7:0]  byte_val;
    logic        func_set, is_long;
    logic        rx_valid_q, rx_rs_q, overrun_q, rs_err_q;
    logic [7:0]  rx_data_q;
    logic [CW-1:0] busy_cnt;

    hd44780_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .e      (bus.e),
        .rs     (bus.rs),
        .db     (bus.db),
        .strobe (strobe),
        .cap_rs (cap_rs),
        .cap_db (cap_db)
    );

    // Mode change takes effect the cycle after the function-set byte is presented
    assign func_set = rx_valid_q && !rx_rs_q && (rx_data_q[7:5] == CMD_FUNC[7:5]);
    assign is_long  = !rx_rs_q && ((rx_data_q == CMD_CLEAR) || (rx_data_q[7:1] == CMD_HOME[7:1]));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_BYTE8;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        byte_done = 1'b0;
        byte_rs   = 1'b0;
        byte_val  = 8'h00;
        hi_load   = 1'b0;
        rs_mis    = 1'b0;
        if (strobe) begin
            case (state)
                ST_BYTE8: begin
                    byte_done = 1'b1;
                    byte_rs   = cap_rs;
                    byte_val  = {cap_db, 4'h0};
                end
                ST_HI4: begin
                    hi_load = 1'b1;
                    state_n = ST_LO4;
                end
                ST_LO4: begin
                    byte_done = 1'b1;
                    byte_rs   = hi_rs;
                    byte_val  = {hi_nib, cap_db};
                    rs_mis    = (cap_rs != hi_rs);
                    state_n   = ST_HI4;
                end
                default: state_n = ST_BYTE8;
            endcase
        end
        if (func_set) state_n = rx_data_q[4] ? ST_BYTE8 : ST_HI4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_nib     <= '0;
            hi_rs      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_rs_q    <= 1'b0;
            rx_data_q  <= '0;
            overrun_q  <= 1'b0;
            rs_err_q   <= 1'b0;
            busy_cnt   <= '0;
        end else begin
            if (hi_load) begin
                hi_nib <= cap_db;
                hi_rs  <= cap_rs;
            end
            rx_valid_q <= byte_done;
            rs_err_q   <= rs_mis;
            overrun_q  <= strobe && (busy_cnt != '0);
            if (byte_done) begin
                rx_rs_q   <= byte_rs;
                rx_data_q <= byte_val;
            end
            if (rx_valid_q)
                busy_cnt <= is_long ? CW'(LONG_BUSY_CYCLES) : CW'(BUSY_CYCLES);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - CW'(1);
        end
    end

    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_rs    = rx_rs_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.mode4    = (state != ST_BYTE8);
    assign bus.busy     = (busy_cnt != '0);
    assign bus.overrun  = overrun_q;
    assign bus.rs_err   = rs_err_q;

`ifdef HD44780_RX_DDRAM_EN
    logic [6:0] ddram_q;
    logic       dir_inc;
    logic       char_we_q;
    logic [6:0] char_addr_q;
    logic [7:0] char_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ddram_q     <= '0;
            dir_inc     <= 1'b1;
            char_we_q   <= 1'b0;
            char_addr_q <= '0;
            char_data_q <= '0;
        end else begin
            char_we_q <= byte_done && byte_rs;
            if (byte_done && byte_rs) begin
                char_addr_q <= ddram_q;
                char_data_q <= byte_val;
                ddram_q     <= next_addr(ddram_q, dir_inc);
            end else if (byte_done) begin
                // Highest set bit selects the command; CGRAM, function set and display control leave the address alone
                if (byte_val[7]) begin
                    ddram_q <= byte_val[6:0];
                end else if (byte_val[6:5] == 2'b00) begin
                    if (byte_val[4]) begin
                        if (!byte_val[3]) ddram_q <= next_addr(ddram_q, byte_val[2]);
                    end else if (!byte_val[3]) begin
                        if (byte_val[2])             dir_inc <= byte_val[1];
                        else if (byte_val[1:0] != 0) ddram_q <= '0;
                    end
                end
            end
        end
    end

    assign bus.char_we    = char_we_q;
    assign bus.char_addr  = char_addr_q;
    assign bus.char_data  = char_data_q;
    assign bus.ddram_addr = ddram_q;
`endif

endmodule

// File: tb/tb_hd44780_rx.sv
// Scoreboard bench for hd44780_rx: drives nibbles on e/rs/db and checks bytes,
// latency, busy length, overrun and rs_err; DDRAM checks only with HD44780_RX_DDRAM_EN.
module tb_hd44780_rx;

    localparam int S = 2;
    localparam int B = 1000;
    localparam int L = 44300;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       err;
        logic [6:0] ca;
        int         fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ov_cnt = 0;
    int   busy_run = 0;
    int   last_busy = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    hd44780_rx_if bus();

    hd44780_rx #(.SYNC_STAGES(S), .BUSY_CYCLES(B), .LONG_BUSY_CYCLES(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t ex;
        if (!rst) begin
            if (bus.rx_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", sb.size(), 1);
                end else begin
                    ex = sb.pop_front();
                    chk("rx_data", bus.rx_data, ex.data);
                    chk("rx_rs", bus.rx_rs, ex.rs);
                    chk("rs_err", bus.rs_err, ex.err);
                    chk("latency", cyc - ex.fall, S + 1);
`ifdef HD44780_RX_DDRAM_EN
                    chk("char_we", bus.char_we, ex.rs);
                    if (ex.rs) begin
                        chk("char_addr", bus.char_addr, ex.ca);
                        chk("char_data", bus.char_data, ex.data);
                    end
`endif
                end
            end else if (bus.rs_err) begin
                chk("rs_err_lone", bus.rx_valid, 1);
            end
            if (prev_valid) chk("busy_rise", bus.busy, 1);
            prev_valid = bus.rx_valid;
            if (bus.overrun) ov_cnt++;
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
        end
    end

    task automatic nib(input logic r, input logic [3:0] d, input bit done, input exp_t ex);
        @(negedge clk);
        bus.rs = r;
        bus.db = d;
        bus.e  = 1'b1;
        repeat (4) @(negedge clk);
        bus.e = 1'b0;
        if (done) begin
            ex.fall = cyc;
            sb.push_back(ex);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic byte8(input logic [3:0] d);
        exp_t x;
        x = '{1'b0, {d, 4'h0}, 1'b0, 7'h00, 0};
        nib(1'b0, d, 1'b1, x);
    endtask

    task automatic byte4(input logic r, input logic [7:0] b, input logic [6:0] ca);
        exp_t x;
        x = '{r, b, 1'b0, ca, 0};
        nib(r, b[7:4], 1'b0, x);
        nib(r, b[3:0], 1'b1, x);
    endtask

    task automatic wait_idle();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 50000 && bus.busy; i++) @(negedge clk);
        chk("idle", bus.busy, 0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.rx_valid, 0);
        chk({tag, "_rs"}, bus.rx_rs, 0);
        chk({tag, "_data"}, bus.rx_data, 0);
        chk({tag, "_mode4"}, bus.mode4, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_overrun"}, bus.overrun, 0);
        chk({tag, "_rs_err"}, bus.rs_err, 0);
`ifdef HD44780_RX_DDRAM_EN
        chk({tag, "_char_we"}, bus.char_we, 0);
        chk({tag, "_ddram"}, bus.ddram_addr, 0);
`endif
    endtask

    initial begin
        exp_t x;
        bus.e  = 1'b0;
        bus.rs = 1'b0;
        bus.db = 4'h0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        // Power-on init: three 0x3 strobes then 0x2 switch to 4-bit mode
        for (int i = 0; i < 4; i++) begin
            byte8((i == 3) ? 4'h2 : 4'h3);
            wait_idle();
            chk("init_busy_len", last_busy, B);
            if (i < 3) chk("init_mode4_low", bus.mode4, 0);
        end
        chk("init_mode4", bus.mode4, 1);

        byte4(1'b1, 8'h41, 7'h00);
        wait_idle();
        chk("data_busy_len", last_busy, B);

        // Clear display, then a high nibble during the long busy time
        ov_cnt = 0;
        byte4(1'b0, 8'h01, 7'h00);
        repeat (480) @(negedge clk);
        x = '{1'b0, 8'h00, 1'b0, 7'h00, 0};
        nib(1'b0, 4'h0, 1'b0, x);
        wait_idle();
        chk("clear_busy_len", last_busy, L);
        chk("overrun_cnt", ov_cnt, 1);

        // Low nibble with RS flipped: byte keeps high-nibble RS, rs_err flagged
        x = '{1'b0, 8'h06, 1'b1, 7'h00, 0};
        nib(1'b1, 4'h6, 1'b1, x);
        wait_idle();
        chk("entry_busy_len", last_busy, B);
        chk("overrun_cnt_after", ov_cnt, 1);

`ifdef HD44780_RX_DDRAM_EN
        byte4(1'b0, 8'hA6, 7'h00);
        wait_idle();
        chk("ddram_set", bus.ddram_addr, 7'h26);
        byte4(1'b1, 8'h41, 7'h26);
        wait_idle();
        byte4(1'b1, 8'h42, 7'h27);
        wait_idle();
        byte4(1'b1, 8'h43, 7'h40);
        wait_idle();
        chk("ddram_wrap", bus.ddram_addr, 7'h41);
        byte4(1'b0, 8'h04, 7'h00);
        wait_idle();
        byte4(1'b1, 8'h44, 7'h41);
        wait_idle();
        chk("ddram_dec", bus.ddram_addr, 7'h40);
`endif

        // Reset with only the high nibble held
        chk("pre_rst_mode4", bus.mode4, 1);
        x = '{1'b0, 8'h00, 1'b0, 7'h00, 0};
        nib(1'b0, 4'h5, 1'b0, x);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midbyte_rst");
        byte8(4'h2);
        wait_idle();
        chk("post_rst_mode4", bus.mode4, 1);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
